alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand/result width; only 8 is supported (matches ALU datapath).
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports in_valid input 1 / in_ready output 1: request handshake.
REQ-005 SHALL have ports in_op input 3, in_a input 8, in_b input 8, in_amt input 5: opcode, operands, shift amount.
REQ-006 SHALL have port in_use_acc input 1: use accumulator as operand A (see Configuration).
REQ-007 SHALL have ports alu_a output 8, alu_b output 8, alu_ctrl output 3, alu_amt output 5: registered drive to the combinational ALU (A, B, ALUControl, Cantidad).
REQ-008 SHALL have ports alu_result input 8, alu_cout input 1: ALU Resultado and C_out.
REQ-009 SHALL have ports out_valid output 1 / out_ready input 1: result handshake.
REQ-010 SHALL have ports out_result output 8, out_carry output 1, out_zero output 1, out_neg output 1.
REQ-011 SHALL have port op_count output 8: completed-operation counter.

Function
REQ-012 SHALL implement FSM states IDLE, EXEC, DONE.
REQ-013 IDLE: in_ready=1; on in_valid=1 SHALL latch in_op/in_a/in_b/in_amt into alu_* registers and go to EXEC.
REQ-014 EXEC: in_ready=0; SHALL capture alu_result/alu_cout into output registers at the edge ending EXEC and go to DONE unconditionally.
REQ-015 DONE: out_valid=1, in_ready=0; on out_ready=1 SHALL go to IDLE and increment op_count by 1 (wraps 255->0).
REQ-016 Latency: accept edge t -> out_valid high from cycle after edge t+1; minimum 3 cycles per operation.
REQ-017 out_valid=0 in IDLE and EXEC; out_* SHALL hold stable while out_valid=1 and out_ready=0.
REQ-018 out_carry SHALL equal alu_cout when captured op is 3'b000 or 3'b001, else 0.
REQ-019 out_zero SHALL be 1 iff captured result == 8'h00; out_neg SHALL equal captured result[7].
REQ-020 alu_* SHALL hold their values outside IDLE acceptance (no glitch to ALU during EXEC/DONE).
REQ-021 in_valid in EXEC/DONE SHALL be ignored (not lost: requester holds it until in_ready).
REQ-022 in_amt SHALL pass unchanged to alu_amt; range interpretation belongs to the ALU.

Reset
REQ-023 rst_n=0 SHALL immediately force state IDLE, alu_a/alu_b/alu_amt=0, alu_ctrl=3'b000, out_result=0, out_carry/out_zero/out_neg=0, out_valid=0, op_count=0, accumulator=0.
REQ-024 Reset during EXEC or DONE SHALL discard the in-flight operation without incrementing op_count.
REQ-025 in_ready SHALL be 1 in the first cycle after rst_n deasserts.

Configuration
REQ-026 Macro ALU_SEQ_ACC_EN defined: 8-bit accumulator loads out_result on each DONE handshake; when in_use_acc=1 at acceptance, alu_a SHALL take the accumulator instead of in_a.
REQ-027 Macro ALU_SEQ_ACC_EN undefined: no accumulator register; in_use_acc ignored; alu_a always from in_a.

Structure
REQ-028 SHALL place FSM state encoding (IDLE=2'd0, EXEC=2'd1, DONE=2'd2) and opcode constants (OP_ADD=3'b000, OP_SUB=3'b001) in shared package alu_seq_pkg.
REQ-029 SHALL put flag generation and output capture registers in one sub-module alu_seq_flags; FSM, operand registers, counter in alu_seq.

Verification
REQ-030 ADD 8'h0F+8'h01 accepted at edge t -> out_valid after edge t+1, out_result=8'h10, carry 0, zero 0, neg 0.
REQ-031 ADD 8'hFF+8'h01 -> out_result=8'h00, out_carry=1, out_zero=1, op_count increments to 1 on handshake.
REQ-032 SUB 8'h05-8'h05 (op 3'b001) -> out_result=8'h00, out_carry=1, out_zero=1; SUB 8'h03-8'h05 -> 8'hFE, carry 0, neg 1.
REQ-033 out_ready held 0 for 5 cycles in DONE -> out_valid and out_* constant, in_ready=0, op_count unchanged; release -> IDLE next cycle.
REQ-034 rst_n pulsed low during EXEC -> all outputs reset values same cycle, op_count=0, next request processed normally.
REQ-035 ALU_SEQ_ACC_EN: ADD 8'h10+8'h01 then ADD with in_use_acc=1, in_b=8'h02 -> alu_a=8'h11, out_result=8'h13; without macro alu_a=in_a.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg -- shared definitions for the sequential ALU wrapper.
//   state_t      : FSM encoding (IDLE=0, EXEC=1, DONE=2)
//   OP_ADD/OP_SUB: opcodes whose ALU carry-out is meaningful
//   op_has_carry : true for the opcodes above
package alu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int OP_W  = 3;
    localparam int AMT_W = 5;

    localparam logic [OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB = 3'b001;

    function automatic logic op_has_carry(input logic [OP_W-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_seq_flags.sv
// alu_seq_flags -- result capture and flag generation.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   capture             : load the ALU outputs this edge (last cycle of EXEC)
//   op                  : opcode currently driven to the ALU
//   alu_result/alu_cout : combinational ALU outputs
//   out_result/out_carry/out_zero/out_neg : registered result and flags
module alu_seq_flags
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             capture,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_cout,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic             out_zero,
    output logic             out_neg
);

    // Flags are computed from the same values being captured so they can
    // never disagree with out_result. Carry from logic/shift ops is noise
    // from the ALU and is masked off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_result <= '0;
            out_carry  <= 1'b0;
            out_zero   <= 1'b0;
            out_neg    <= 1'b0;
        end else if (capture) begin
            out_result <= alu_result;
            out_carry  <= alu_cout & op_has_carry(op);
            out_zero   <= (alu_result == '0);
            out_neg    <= alu_result[WIDTH-1];
        end
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq -- handshake sequencer around an external combinational ALU.
// Accepts a request in IDLE, registers the operands onto alu_* for one EXEC
// cycle, captures the ALU result, then presents it in DONE until out_ready.
// Ports:
//   clk, rst_n                        : clock, async active-low reset
//   in_valid/in_ready                 : request handshake
//   in_op, in_a, in_b, in_amt         : opcode, operands, shift amount
//   in_use_acc                        : take operand A from the accumulator
//   alu_a, alu_b, alu_ctrl, alu_amt   : registered drive to the ALU
//   alu_result, alu_cout              : ALU outputs
//   out_valid/out_ready               : result handshake
//   out_result, out_carry, out_zero, out_neg : result and flags
//   op_count                          : completed operations (wraps)
// Build option: define ALU_SEQ_ACC_EN to add the 8-bit accumulator; without
// it in_use_acc is ignored and alu_a always comes from in_a.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [AMT_W-1:0] in_amt,
    input  logic             in_use_acc,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OP_W-1:0]  alu_ctrl,
    output logic [AMT_W-1:0] alu_amt,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic             out_zero,
    output logic             out_neg,
    output logic [7:0]       op_count
);

    state_t           state, state_nxt;
    logic             accept, capture, handshake;
    logic [WIDTH-1:0] a_src;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        capture   = 1'b0;
        handshake = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                capture   = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    handshake = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef ALU_SEQ_ACC_EN
    logic [WIDTH-1:0] acc;

    // Accumulator follows every delivered result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         acc <= '0;
        else if (handshake) acc <= out_result;
    end

    assign a_src = in_use_acc ? acc : in_a;
`else
    logic unused_use_acc;
    assign unused_use_acc = in_use_acc;
    assign a_src          = in_a;
`endif

    // Operand registers only move on acceptance so the ALU inputs are
    // quiet for the whole EXEC/DONE window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a    <= '0;
            alu_b    <= '0;
            alu_ctrl <= OP_ADD;
            alu_amt  <= '0;
        end else if (accept) begin
            alu_a    <= a_src;
            alu_b    <= in_b;
            alu_ctrl <= in_op;
            alu_amt  <= in_amt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         op_count <= 8'd0;
        else if (handshake) op_count <= op_count + 8'd1;
    end

    alu_seq_flags #(.WIDTH(WIDTH)) u_flags (
        .clk        (clk),
        .rst_n      (rst_n),
        .capture    (capture),
        .op         (alu_ctrl),
        .alu_result (alu_result),
        .alu_cout   (alu_cout),
        .out_result (out_result),
        .out_carry  (out_carry),
        .out_zero   (out_zero),
        .out_neg    (out_neg)
    );

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq -- randomized self-checking bench for alu_seq.
// The bench provides the combinational ALU and an arithmetic reference model
// of the whole operation (result, flags, counter, accumulator).
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready;
    logic [2:0] in_op;
    logic [7:0] in_a, in_b;
    logic [4:0] in_amt;
    logic       in_use_acc;
    logic [7:0] alu_a, alu_b;
    logic [2:0] alu_ctrl;
    logic [4:0] alu_amt;
    logic [7:0] alu_result;
    logic       alu_cout;
    logic       out_valid, out_ready;
    logic [7:0] out_result;
    logic       out_carry, out_zero, out_neg;
    logic [7:0] op_count;

    int n_chk = 0;
    int n_err = 0;
    int cnt_m = 0;
    int acc_m = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_amt(in_amt),
        .in_use_acc(in_use_acc),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_amt(alu_amt),
        .alu_result(alu_result), .alu_cout(alu_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_carry(out_carry),
        .out_zero(out_zero), .out_neg(out_neg),
        .op_count(op_count)
    );

    // External ALU; carry-out of non-arithmetic ops is deliberately noisy.
    always_comb begin
        alu_result = 8'h00;
        alu_cout   = 1'b0;
        case (alu_ctrl)
            3'd0: {alu_cout, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
            3'd1: begin alu_result = alu_a - alu_b; alu_cout = (alu_a >= alu_b); end
            3'd2: begin alu_result = alu_a & alu_b; alu_cout = 1'b1; end
            3'd3: begin alu_result = alu_a | alu_b; alu_cout = alu_a[0]; end
            3'd4: begin alu_result = alu_a ^ alu_b; alu_cout = 1'b1; end
            3'd5: begin alu_result = alu_a << alu_amt; alu_cout = alu_a[7]; end
            3'd6: begin alu_result = alu_a >> alu_amt; alu_cout = alu_a[0]; end
            default: begin alu_result = ~alu_a; alu_cout = 1'b1; end
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected result and carry flag from plain integer arithmetic.
    function automatic void ref_op(input int op, input int a, input int b, input int amt,
                                   output int res, output int c);
        c = 0;
        case (op)
            0: begin res = (a + b) % 256;       c = (a + b > 255) ? 1 : 0; end
            1: begin res = (a - b + 256) % 256; c = (a >= b) ? 1 : 0; end
            2: res = a & b;
            3: res = a | b;
            4: res = a ^ b;
            5: res = (amt >= 8) ? 0 : (a * (1 << amt)) % 256;
            6: res = (amt >= 8) ? 0 : a / (1 << amt);
            default: res = 255 - a;
        endcase
    endfunction

    // One full transaction starting and ending at a falling edge in IDLE.
    task automatic do_op(input int op, input int a, input int b, input int amt,
                         input int use_acc, input int hold);
        int a_eff, res, c;
        a_eff = a;
`ifdef ALU_SEQ_ACC_EN
        if (use_acc != 0) a_eff = acc_m;
`endif
        ref_op(op, a_eff, b, amt, res, c);

        check("idle_ready", 32'(in_ready), 1);
        check("idle_valid", 32'(out_valid), 0);
        in_valid   = 1'b1;
        in_op      = 3'(op);
        in_a       = 8'(a);
        in_b       = 8'(b);
        in_amt     = 5'(amt);
        in_use_acc = 1'(use_acc);
        @(negedge clk);

        // EXEC: requester keeps offering junk, which must be ignored.
        in_op  = 3'($urandom);
        in_a   = 8'($urandom);
        in_b   = 8'($urandom);
        in_amt = 5'($urandom);
        check("exec_ready", 32'(in_ready), 0);
        check("exec_valid", 32'(out_valid), 0);
        check("alu_a", 32'(alu_a), a_eff);
        check("alu_b", 32'(alu_b), b);
        check("alu_ctrl", 32'(alu_ctrl), op);
        check("alu_amt", 32'(alu_amt), amt);
        @(negedge clk);

        for (int i = 0; i <= hold; i++) begin
            check("done_valid", 32'(out_valid), 1);
            check("done_ready", 32'(in_ready), 0);
            check("result", 32'(out_result), res);
            check("carry", 32'(out_carry), c);
            check("zero", 32'(out_zero), (res == 0) ? 1 : 0);
            check("neg", 32'(out_neg), (res >= 128) ? 1 : 0);
            check("done_cnt", 32'(op_count), cnt_m);
            check("hold_alu_a", 32'(alu_a), a_eff);
            if (i < hold) @(negedge clk);
        end

        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        cnt_m = (cnt_m + 1) % 256;
        acc_m = res;
        check("post_valid", 32'(out_valid), 0);
        check("post_ready", 32'(in_ready), 1);
        check("post_cnt", 32'(op_count), cnt_m);
    endtask

    task automatic check_reset_vals();
        check("rst_ready", 32'(in_ready), 1);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_alu", 32'({alu_a, alu_b, alu_ctrl, alu_amt}), 0);
        check("rst_out", 32'({out_result, out_carry, out_zero, out_neg}), 0);
        check("rst_cnt", 32'(op_count), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_op = 3'd0; in_a = 8'd0; in_b = 8'd0;
        in_amt = 5'd0; in_use_acc = 1'b0; out_ready = 1'b0;
        #1;
        check_reset_vals();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        do_op(0, 8'h0F, 8'h01, 0, 0, 0);
        do_op(0, 8'hFF, 8'h01, 0, 0, 0);
        do_op(1, 8'h05, 8'h05, 0, 0, 0);
        do_op(1, 8'h03, 8'h05, 0, 0, 0);
        do_op(0, 8'h03, 8'h04, 0, 0, 5);
        do_op(0, 8'h10, 8'h01, 0, 0, 0);
        do_op(0, 8'h77, 8'h02, 0, 1, 0);
        do_op(2, 8'hF0, 8'h3C, 0, 0, 0);
        do_op(5, 8'h81, 8'h00, 1, 0, 0);
        do_op(5, 8'h81, 8'h00, 8, 0, 0);
        do_op(6, 8'h80, 8'h00, 31, 0, 1);

        // Reset in the middle of EXEC drops the operation.
        in_valid = 1'b1; in_op = 3'd0; in_a = 8'h0F; in_b = 8'h01;
        in_amt = 5'd0; in_use_acc = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_reset_vals();
        @(negedge clk);
        rst_n = 1'b1;
        cnt_m = 0;
        acc_m = 0;
        do_op(0, 8'h0F, 8'h01, 0, 0, 0);

        // Enough random traffic to wrap op_count.
        for (int k = 0; k < 270; k++)
            do_op(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 255)), int'($urandom_range(0, 31)),
                  int'($urandom_range(0, 1)), int'($urandom_range(0, 2)));

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
